sm_reg_dumper: RTL

SM_REG_DUMPER -- requirements
Module: sm_reg_dumper

---
 rtl/sm_reg_dumper.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sm_reg_dumper.sv
// ---------------------------------------------------------------------------
// sm_reg_dumper
//
// Walks the CPU debug register file from FIRST_REG to LAST_REG and streams it
// out as a byte stream with a valid/ready handshake. Stream layout:
//   HEADER, then for each register: {3'b000, index}, data[31:24], data[23:16],
//   data[15:8], data[7:0].
// Each register is snapshotted into a capture register during a single ADDR
// cycle, so the streamed value does not follow later changes of regData.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request a dump (only honoured while idle)
//   regAddr   out  5   debug register address to the CPU
//   regData   in  32   debug register data, combinational from regAddr
//   outData   out  8   stream byte
//   outValid  out  1   outData holds a valid byte
//   outReady  in   1   consumer accepts the byte when outValid && outReady
//   busy      out  1   dump in progress (HDR..DATA)
//   done      out  1   one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module sm_reg_dumper #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        IDX,
        DATA,
        FIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  addr_cnt;
    logic [31:0] capture;
    logic [1:0]  byte_cnt;

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. The outputs depend only on registered
    // state, so outData/outValid stay stable while a byte is stalled.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        outValid   = 1'b0;
        outData    = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                busy     = 1'b1;
                outValid = 1'b1;
                outData  = HEADER;
                if (outReady) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // regAddr has been stable for this whole cycle; capture
                // takes regData at the closing edge.
                busy       = 1'b1;
                state_next = IDX;
            end
            IDX: begin
                busy     = 1'b1;
                outValid = 1'b1;
                outData  = {3'b000, addr_cnt};
                if (outReady) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                busy     = 1'b1;
                outValid = 1'b1;
                case (byte_cnt)
                    2'd0:    outData = capture[31:24];
                    2'd1:    outData = capture[23:16];
                    2'd2:    outData = capture[15:8];
                    default: outData = capture[7:0];
                endcase
                if (outReady && (byte_cnt == 2'd3)) begin
                    state_next = (addr_cnt == LAST_ADDR) ? FIN : ADDR;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: address counter, capture register and byte counter.
    // NOTE: the capture register is reset like the control state, so the
    // stream never exposes a value left over from before reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= FIRST_ADDR;
            capture  <= 32'h0000_0000;
            byte_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt <= FIRST_ADDR;
                    end
                end
                ADDR: begin
                    capture <= regData;
                end
                IDX: begin
                    if (outReady) begin
                        byte_cnt <= 2'd0;
                    end
                end
                DATA: begin
                    if (outReady) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        // Terminal check comes first, so the counter never
                        // wraps past register 31.
                        if ((byte_cnt == 2'd3) && (addr_cnt != LAST_ADDR)) begin
                            addr_cnt <= addr_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The address counter holds its last value outside a dump.
    assign regAddr = addr_cnt;

endmodule
